// File: rtl/chu_vga_multi_sprite_pkg.sv
// Shared definitions for the multi-sprite overlay slot: register map offsets,
// ctrl bit positions, slot bus widths and the per-sprite register record.
package chu_vga_multi_sprite_pkg;

    localparam int unsigned COORD_W     = 11;
    localparam int unsigned SLOT_ADDR_W = 14;
    localparam int unsigned SLOT_DATA_W = 32;

    // addr[13] selects the register page; pixel RAM lives below it
    localparam int unsigned REG_PAGE_BIT = 13;

    // Register offsets within one sprite's register group (addr[1:0])
    localparam logic [1:0] REG_X      = 2'd0;
    localparam logic [1:0] REG_Y      = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_GLOBAL = 2'd3;

    // Bit positions inside the ctrl word
    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_HMIRROR_BIT = 1;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               en;
        logic               hmirror;
    } spr_regs_t;

    // True when the coordinate is the frame origin
    function automatic logic is_origin(input logic [COORD_W-1:0] px,
                                       input logic [COORD_W-1:0] py);
        return (px == '0) && (py == '0);
    endfunction

endpackage

// File: rtl/chu_sprite_ram.sv
// Simple dual-port synchronous sprite pixel RAM, one write and one read port.
// Read-first: a read of an address written in the same cycle returns the old
// word; the new word is visible from the next cycle. Contents are not reset.
//   clk     : system clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data (one cycle latency)
module chu_sprite_ram #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read share the clock edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/chu_vga_multi_sprite_core.sv
// N-sprite overlay stage for the video daisy chain. Sprites have fixed
// priority (lowest index on top), optional horizontal mirroring, shadowed
// position/ctrl registers committed at frame start, and a per-frame
// sprite-to-sprite collision report. Two-cycle latency si_rgb -> so_rgb.
//   clk       : system clock
//   reset     : asynchronous, active-low reset
//   x, y      : current pixel coordinate from the frame counter
//   cs, write : slot select / write strobe
//   addr      : slot word address (pixel RAM page or register page)
//   wr_data   : slot write data
//   si_rgb    : upstream pixel
//   so_rgb    : composited pixel (registered)
//   collision : per-sprite collision flags of the last completed frame
module chu_vga_multi_sprite_core
    import chu_vga_multi_sprite_pkg::*;
#(
    parameter int unsigned CD         = 12,
    parameter int unsigned NUM_SPR    = 4,
    parameter int unsigned SPR_W_BITS = 5,
    parameter int unsigned SPR_H_BITS = 5,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned KEY_COLOR  = 0,
    parameter int unsigned HMAX       = 640,
    parameter int unsigned VMAX       = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COORD_W-1:0]     x,
    input  logic [COORD_W-1:0]     y,
    input  logic                   cs,
    input  logic                   write,
    input  logic [SLOT_ADDR_W-1:0] addr,
    input  logic [SLOT_DATA_W-1:0] wr_data,
    input  logic [CD-1:0]          si_rgb,
    output logic [CD-1:0]          so_rgb,
    output logic [NUM_SPR-1:0]     collision
);

    localparam int unsigned SPR_W = 1 << SPR_W_BITS;
    localparam int unsigned SPR_H = 1 << SPR_H_BITS;
    localparam logic [CD-1:0] KEY = CD'(KEY_COLOR);

    // ---------------------------------------------------------------
    // Frame-start detection: origin reached from a non-origin pixel
    // ---------------------------------------------------------------
    logic [COORD_W-1:0] x_prev_q, y_prev_q;
    logic               frame_start_c;

    assign frame_start_c = is_origin(x, y) && !is_origin(x_prev_q, y_prev_q);

    // ---------------------------------------------------------------
    // Slot write decode
    // ---------------------------------------------------------------
    logic       wr_en_c, reg_wr_c, ram_wr_c;
    logic [2:0] reg_idx_c, ram_idx_c;
    logic       unused_wr_bits;

    assign wr_en_c   = cs && write;
    assign reg_wr_c  = wr_en_c && addr[REG_PAGE_BIT];
    assign ram_wr_c  = wr_en_c && !addr[REG_PAGE_BIT];
    assign reg_idx_c = addr[4:2];
    assign ram_idx_c = addr[12:10];

    assign unused_wr_bits = ^wr_data[SLOT_DATA_W-1:CD];

    // ---------------------------------------------------------------
    // Pending (CPU-visible) and active (display) sprite registers
    // ---------------------------------------------------------------
    spr_regs_t pend_q [NUM_SPR];
    spr_regs_t act_q  [NUM_SPR];
    logic      bypass_q;

    // Commit samples pending before any same-cycle write lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_SPR); i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
            end
            bypass_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_SPR); i++) begin
                if (frame_start_c) begin
                    act_q[i] <= pend_q[i];
                end
                if (reg_wr_c && (reg_idx_c == 3'(i))) begin
                    case (addr[1:0])
                        REG_X:    pend_q[i].x <= wr_data[COORD_W-1:0];
                        REG_Y:    pend_q[i].y <= wr_data[COORD_W-1:0];
                        REG_CTRL: begin
                            pend_q[i].en      <= wr_data[CTRL_EN_BIT];
                            pend_q[i].hmirror <= wr_data[CTRL_HMIRROR_BIT];
                        end
                        default: ;
                    endcase
                end
            end
            if (reg_wr_c && (reg_idx_c == 3'd0) && (addr[1:0] == REG_GLOBAL)) begin
                bypass_q <= wr_data[0];
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: per-sprite hit test and pixel RAM read
    // ---------------------------------------------------------------
    logic              in_frame_c;
    logic [NUM_SPR-1:0] hit_c, hit_q;
    logic [CD-1:0]     pix_q [NUM_SPR];

    assign in_frame_c = (x < COORD_W'(HMAX)) && (y < COORD_W'(VMAX));

    for (genvar g = 0; g < int'(NUM_SPR); g++) begin : g_spr
        spr_regs_t               view_c;
        logic [COORD_W-1:0]      dx_c, dy_c;
        logic [SPR_W_BITS-1:0]   col_c;
        logic [ADDR_WIDTH-1:0]   rd_addr_c;

        // The frame-start pixel already belongs to the newly committed frame
        assign view_c = frame_start_c ? pend_q[g] : act_q[g];

        // Unsigned wrap makes positions left/above the sprite fall out of range
        assign dx_c = x - view_c.x;
        assign dy_c = y - view_c.y;

        assign hit_c[g] = view_c.en && in_frame_c &&
                          (dx_c < COORD_W'(SPR_W)) && (dy_c < COORD_W'(SPR_H));

        assign col_c     = view_c.hmirror ? ~dx_c[SPR_W_BITS-1:0] : dx_c[SPR_W_BITS-1:0];
        assign rd_addr_c = ADDR_WIDTH'({dy_c[SPR_H_BITS-1:0], col_c});

        chu_sprite_ram #(
            .DATA_W (CD),
            .ADDR_W (ADDR_WIDTH)
        ) u_ram (
            .clk     (clk),
            .we      (ram_wr_c && (ram_idx_c == 3'(g))),
            .wr_addr (addr[ADDR_WIDTH-1:0]),
            .wr_data (wr_data[CD-1:0]),
            .rd_addr (rd_addr_c),
            .rd_data (pix_q[g])
        );
    end

    logic [CD-1:0] si_d1_q;
    logic          fs_d1_q;

    // Stage 1 pipeline registers, aligned with the RAM read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_prev_q <= '0;
            y_prev_q <= '0;
            hit_q    <= '0;
            si_d1_q  <= '0;
            fs_d1_q  <= 1'b0;
        end else begin
            x_prev_q <= x;
            y_prev_q <= y;
            hit_q    <= hit_c;
            si_d1_q  <= si_rgb;
            fs_d1_q  <= frame_start_c;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: opacity, priority mux and collision accumulation
    // ---------------------------------------------------------------
    logic [NUM_SPR-1:0] opaque_c, coll_hit_c, coll_acc_q;
    logic [CD-1:0]      mux_c;

    // Walk from highest index down so the lowest opaque index wins
    always_comb begin
        opaque_c = '0;
        mux_c    = si_d1_q;
        for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
            if (hit_q[i] && (pix_q[i] != KEY)) begin
                opaque_c[i] = 1'b1;
                mux_c       = pix_q[i];
            end
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something
    assign coll_hit_c = ((opaque_c & (opaque_c - NUM_SPR'(1))) != '0) ? opaque_c : '0;

    // Output register; frame-start pixel seeds the fresh accumulator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            so_rgb     <= '0;
            collision  <= '0;
            coll_acc_q <= '0;
        end else begin
            so_rgb <= bypass_q ? si_d1_q : mux_c;
            if (fs_d1_q) begin
                collision  <= coll_acc_q;
                coll_acc_q <= coll_hit_c;
            end else begin
                coll_acc_q <= coll_acc_q | coll_hit_c;
            end
        end
    end

endmodule

// File: tb/tb_chu_vga_multi_sprite_core.sv
// Self-checking bench for chu_vga_multi_sprite_core: table vectors, directed
// multi-cycle sequences and randomized traffic against a pixel-level model.
module tb_chu_vga_multi_sprite_core;

    localparam int NS = 4;
    localparam logic [11:0] KEY = 12'h000;

    logic              clk = 1'b0;
    logic              reset;
    logic [10:0]       x, y;
    logic              cs, write;
    logic [13:0]       addr;
    logic [31:0]       wr_data;
    logic [11:0]       si_rgb, so_rgb;
    logic [NS-1:0]     collision;

    always #5 clk = ~clk;

    chu_vga_multi_sprite_core #(
        .CD(12), .NUM_SPR(NS), .SPR_W_BITS(5), .SPR_H_BITS(5),
        .ADDR_WIDTH(10), .KEY_COLOR(0), .HMAX(640), .VMAX(480)
    ) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write),
        .addr(addr), .wr_data(wr_data), .si_rgb(si_rgb),
        .so_rgb(so_rgb), .collision(collision)
    );

    int checks, errors;

    // Reference model state
    int            p_x [NS], p_y [NS], a_x [NS], a_y [NS];
    bit            p_en [NS], p_hm [NS], a_en [NS], a_hm [NS];
    bit            m_bypass;
    bit [NS-1:0]   m_acc, m_coll;
    int            prev_x, prev_y;
    logic [11:0]   ram_m [NS][1024];
    logic [11:0]   exp_so;
    logic [NS-1:0] exp_coll;

    typedef struct {
        int          xv;
        int          yv;
        logic [11:0] si;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl_a [8];
    vec_t tbl_b [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic vec_t mk(input int xv, input int yv, input logic [11:0] si, input logic [11:0] e);
        vec_t v;
        v.xv = xv; v.yv = yv; v.si = si; v.exp = e;
        return v;
    endfunction

    function automatic logic [13:0] ram_addr(input int s, input int a);
        return 14'((s << 10) | a);
    endfunction

    function automatic logic [13:0] reg_addr(input int s, input int r);
        return 14'(32'h2000 | (s << 2) | r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            p_x[i] = 0; p_y[i] = 0; p_en[i] = 0; p_hm[i] = 0;
            a_x[i] = 0; a_y[i] = 0; a_en[i] = 0; a_hm[i] = 0;
        end
        m_bypass = 0; m_acc = '0; m_coll = '0;
        prev_x = 0; prev_y = 0;
        exp_so = '0; exp_coll = '0;
    endtask

    // One pixel clock: drive inputs, predict, clock, compare previous prediction
    task automatic tick(input int xv, input int yv, input int siv,
                        input bit we = 1'b0, input logic [13:0] av = '0,
                        input logic [31:0] dv = '0);
        bit          fs;
        int          dx, dy, pa, nop, idx;
        logic [11:0] comp, pix, new_so;
        logic [NS-1:0] om;
        x = 11'(xv); y = 11'(yv); si_rgb = 12'(siv);
        cs = we; write = we; addr = av; wr_data = dv;

        fs = (xv == 0 && yv == 0) && !(prev_x == 0 && prev_y == 0);
        if (fs) begin
            for (int i = 0; i < NS; i++) begin
                a_x[i] = p_x[i]; a_y[i] = p_y[i]; a_en[i] = p_en[i]; a_hm[i] = p_hm[i];
            end
        end
        comp = 12'(siv); om = '0; nop = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            dx = (xv - a_x[i]) & 2047;
            dy = (yv - a_y[i]) & 2047;
            if (a_en[i] && xv < 640 && yv < 480 && dx < 32 && dy < 32) begin
                pa  = dy * 32 + (a_hm[i] ? 31 - dx : dx);
                pix = ram_m[i][pa];
                if (pix != KEY) begin
                    comp = pix; om[i] = 1'b1; nop++;
                end
            end
        end
        if (fs) begin
            m_coll = m_acc;
            m_acc  = '0;
        end
        if (nop >= 2) m_acc |= om;
        prev_x = xv; prev_y = yv;

        if (we) begin
            if (!av[13]) begin
                if (int'(av[12:10]) < NS) ram_m[av[12:10]][av[9:0]] = dv[11:0];
            end else begin
                idx = int'(av[4:2]);
                if (idx < NS) begin
                    case (av[1:0])
                        2'd0: p_x[idx] = int'(dv[10:0]);
                        2'd1: p_y[idx] = int'(dv[10:0]);
                        2'd2: begin p_en[idx] = dv[0]; p_hm[idx] = dv[1]; end
                        default: if (idx == 0) m_bypass = dv[0];
                    endcase
                end
            end
        end
        new_so = m_bypass ? 12'(siv) : comp;

        @(posedge clk); #1;
        check("so_model", 32'(so_rgb), 32'(exp_so));
        check("coll_model", 32'(collision), 32'(exp_coll));
        exp_so = new_so; exp_coll = m_coll;
    endtask

    task automatic park();
        tick(700, 500, 12'h0AA);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        tick(700, 500, 12'h0AA, 1'b1, a, d);
    endtask

    task automatic wreg(input int s, input int r, input int v);
        wr(reg_addr(s, r), 32'(v));
    endtask

    task automatic fill(input int s, input logic [11:0] v);
        for (int a = 0; a < 1024; a++) wr(ram_addr(s, a), 32'(v));
    endtask

    task automatic frame();
        tick(5, 5, 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
    endtask

    // Pixel then one filler cycle; so_rgb then shows that pixel
    task automatic probe(input string n, input int xv, input int yv,
                         input logic [11:0] siv, input logic [11:0] e);
        tick(xv, yv, int'(siv));
        park();
        check(n, 32'(so_rgb), 32'(e));
    endtask

    task automatic run_vec(input string n, input vec_t v);
        probe(n, v.xv, v.yv, v.si, v.exp);
    endtask

    task automatic do_reset();
        cs = 0; write = 0;
        reset = 1'b0;
        #1;
        check("rst_so", 32'(so_rgb), 32'h0);
        check("rst_coll", 32'(collision), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        x = '0; y = '0; cs = 0; write = 0; addr = '0; wr_data = '0; si_rgb = '0;
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < 1024; a++) ram_m[s][a] = '0;

        tbl_a[0] = mk(100, 50, 12'h111, 12'hF00);
        tbl_a[1] = mk(131, 81, 12'h111, 12'hF00);
        tbl_a[2] = mk(115, 60, 12'h111, 12'hF00);
        tbl_a[3] = mk( 99, 50, 12'h111, 12'h111);
        tbl_a[4] = mk(132, 50, 12'h111, 12'h111);
        tbl_a[5] = mk(100, 49, 12'h111, 12'h111);
        tbl_a[6] = mk(100, 82, 12'h111, 12'h111);
        tbl_a[7] = mk(131, 82, 12'h111, 12'h111);

        tbl_b[0] = mk(630, 100, 12'h777, 12'hABC);
        tbl_b[1] = mk(639, 100, 12'h777, 12'hABC);
        tbl_b[2] = mk(629, 100, 12'h777, 12'h777);
        tbl_b[3] = mk(645, 100, 12'h777, 12'h777);
        tbl_b[4] = mk(  0, 100, 12'h777, 12'h777);
        tbl_b[5] = mk(  1, 100, 12'h777, 12'h777);
        tbl_b[6] = mk(639, 131, 12'h777, 12'hABC);
        tbl_b[7] = mk(639, 132, 12'h777, 12'h777);

        do_reset();
        for (int s = 0; s < NS; s++) fill(s, 12'h000);

        // Single sprite window
        fill(0, 12'hF00);
        wreg(0, 0, 100); wreg(0, 1, 50); wreg(0, 2, 1);
        frame();
        for (int i = 0; i < 8; i++) run_vec("win", tbl_a[i]);

        // Two overlapping sprites: priority and collision
        fill(0, 12'h0F0); fill(1, 12'h00F);
        wreg(0, 0, 200); wreg(0, 1, 200);
        wreg(1, 0, 200); wreg(1, 1, 200); wreg(1, 2, 1);
        frame();
        check("coll_before", 32'(collision), 32'h0);
        probe("overlap_a", 210, 210, 12'h333, 12'h0F0);
        probe("overlap_b", 231, 231, 12'h333, 12'h0F0);
        frame();
        check("coll_after", 32'(collision), 32'h3);

        // Horizontal mirror: column dx=0 shows at x = 10+31
        fill(2, 12'h000);
        for (int dy = 0; dy < 32; dy++) wr(ram_addr(2, dy * 32), 32'h123);
        wreg(2, 0, 10); wreg(2, 1, 10); wreg(2, 2, 3);
        frame();
        for (int xi = 5; xi <= 50; xi++)
            probe("mirror", xi, 10, 12'h555, (xi == 41) ? 12'h123 : 12'h555);
        probe("mirror_bot", 41, 41, 12'h555, 12'h123);

        // Shadowed position update
        wreg(0, 0, 300);
        probe("shadow_old", 210, 205, 12'h444, 12'h0F0);
        probe("shadow_new_pre", 310, 205, 12'h444, 12'h444);
        frame();
        probe("shadow_moved", 310, 205, 12'h444, 12'h0F0);
        probe("shadow_vacated", 210, 205, 12'h444, 12'h00F);
        tick(5, 5, 0);
        tick(0, 0, 0, 1'b1, reg_addr(0, 0), 32'd200);
        tick(1, 0, 0);
        probe("fs_write_late", 210, 205, 12'h444, 12'h00F);
        probe("fs_write_stay", 310, 205, 12'h444, 12'h0F0);
        frame();
        probe("fs_write_moved", 210, 205, 12'h444, 12'h0F0);

        // Right edge clipping
        fill(3, 12'hABC);
        wreg(3, 0, 630); wreg(3, 1, 100); wreg(3, 2, 1);
        frame();
        for (int i = 0; i < 8; i++) run_vec("edge", tbl_b[i]);

        // Bypass, and global register only decoded for sprite 0
        wreg(0, 3, 1);
        probe("bypass", 210, 205, 12'h5A5, 12'h5A5);
        for (int n = 0; n < 50; n++)
            tick($urandom_range(190, 240), $urandom_range(190, 240), $urandom_range(0, 4095));
        wreg(0, 3, 0);
        wreg(1, 3, 1);
        probe("bypass_other", 210, 205, 12'h5A5, 12'h0F0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r, r2, xv, yv;
            logic [13:0] av;
            logic [31:0] dv;
            bit we;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                xv = 0; yv = 0;
            end else if (r < 80) begin
                xv = $urandom_range(150, 330); yv = $urandom_range(150, 260);
            end else begin
                xv = $urandom_range(0, 2047); yv = $urandom_range(0, 2047);
            end
            we = 1'b0; av = '0; dv = '0;
            r2 = $urandom_range(0, 99);
            if (r2 < 4) begin
                we = 1'b1;
                av = {1'b1, 8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
                if (av[1] == 1'b0) dv = {21'($urandom), 11'($urandom_range(150, 300))};
                else dv = 32'($urandom);
            end else if (r2 < 14) begin
                we = 1'b1;
                av = {1'b0, 3'($urandom_range(0, 7)), 10'($urandom)};
                dv = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            end
            tick(xv, yv, $urandom_range(0, 4095), we, av, dv);
        end

        // Mid-frame reset, then re-enable
        wreg(0, 3, 0);
        wreg(0, 0, 200); wreg(0, 1, 200); wreg(0, 2, 1);
        wr(ram_addr(0, 5 * 32 + 10), 32'h9AB);
        frame();
        tick(210, 205, 12'h111);
        tick(211, 205, 12'h111);
        do_reset();
        probe("post_rst", 210, 205, 12'h222, 12'h222);
        frame();
        probe("post_rst_frame", 210, 205, 12'h222, 12'h222);
        check("post_rst_coll", 32'(collision), 32'h0);
        wr(ram_addr(0, 5 * 32 + 10), 32'h9AB);
        wreg(0, 0, 200); wreg(0, 1, 200); wreg(0, 2, 1);
        probe("reenable_pending", 210, 205, 12'h222, 12'h222);
        frame();
        probe("reenable", 210, 205, 12'h222, 12'h9AB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chu_vga_multi_sprite_core.md
# chu_vga_multi_sprite_core

Parametrised N-sprite overlay stage for the video daisy chain. It replaces a stack of single-sprite slot cores with one slot holding NUM_SPR independent sprites. Features: fixed priority, horizontal mirroring, tear-free position updates (shadow registers committed at frame start) and a per-frame sprite-to-sprite collision report. It sits between any two stages of the pixel stream (si_rgb → so_rgb), using the shared x/y frame counter and a standard video-slot write port.

## Interface
- CD, 12, colour depth
- NUM_SPR, 4, sprite count (1..8)
- SPR_W_BITS, 5, log2 sprite width (32 px)
- SPR_H_BITS, 5, log2 sprite height (32 px)
- ADDR_WIDTH, 10, per-sprite pixel RAM address width (= SPR_W_BITS+SPR_H_BITS)
- KEY_COLOR, 0, transparent colour
- HMAX / VMAX, 640 / 480, active frame size

Ports:
- clk  in  1  system clock
- reset  in  1  reset; one clock; reset is asynchronous and active-low
- x, y  in  11 each  current pixel coordinate from frame counter
- cs, write  in  1 each  slot select / write strobe
- addr  in  14  slot word address
- wr_data  in  32  write data
- si_rgb  in  CD  upstream pixel
- so_rgb  out  CD  composited pixel
- collision  out  NUM_SPR  per-sprite collision flags of the last completed frame

## Operation
- Address map, writes only, effective when cs && write:
  - addr[13]=0: pixel RAM write. Sprite index is addr[12:10]; pixel address is addr[9:0]; data is wr_data[CD-1:0]. Index ≥ NUM_SPR is ignored.
  - addr[13]=1, addr[4:2]=sprite i, addr[1:0] selects:
    - 0: pending x_i = wr_data[10:0]
    - 1: pending y_i = wr_data[10:0]
    - 2: pending ctrl_i, where bit0 = enable and bit1 = hmirror
    - 3 (i=0 only): global bypass = wr_data[0]
- Pending registers are copied to active registers on the frame-start cycle. The bypass register takes effect immediately.
- Frame-start cycle: (x,y)==(0,0) while the registered previous (x,y) != (0,0). It occurs once per frame, even while x/y stall.
- Hit test for sprite i:
  - enable_i active, and x−x_i in [0, 2^SPR_W_BITS), and y−y_i in [0, 2^SPR_H_BITS).
  - Subtraction is unsigned 11-bit. Wrap produces a large value, so there is no hit.
- Pixel address: {dy, dx}, or {dy, ~dx} when hmirror is set.
- Sprite i is opaque when it hits and its RAM pixel != KEY_COLOR.
- so_rgb is the pixel of the lowest-index opaque sprite, else si_rgb. Bypass forces so_rgb = si_rgb (delayed).
- Collision:
  - If ≥2 sprites are opaque on one pixel, every opaque sprite's bit is ORed into an accumulator.
  - On frame start the accumulator is copied to collision and cleared. A hit on the frame-start pixel goes into the new accumulator.

## Timing
- Latency is 2 cycles from x/y/si_rgb to so_rgb:
  - stage 1: hit test registered + RAM read
  - stage 2: priority mux registered
- si_rgb is delayed 2 cycles internally for alignment.
- Stalls: pipeline advances every clk. Downstream alignment is the daisy chain's responsibility, matching the existing 2-stage start/inc delay line.
- A RAM write followed by a read of the same address returns the new data from the next cycle (read-first port).
- Reset values:
  - so_rgb = 0, collision = 0, accumulator = 0, bypass = 0
  - all enables = 0; x/y registers = 0
  - RAM contents are not reset
- Asserting reset mid-frame clears state immediately. After release, the first frame-start commits the pending registers, which are still 0 disabled.
- A register write in the same cycle as frame start: the commit uses the old pending value. The new value commits at the next frame.

## Structure
- Package chu_vga_multi_sprite_pkg holds:
  - register offset constants (REG_X, REG_Y, REG_CTRL, REG_GLOBAL)
  - ctrl bit positions
  - typedef spr_regs_t {x, y, en, hmirror}
- Sub-module chu_sprite_ram: simple dual-port synchronous RAM, CD × 2^ADDR_WIDTH, one write port and one read port. Instantiated NUM_SPR times in a generate loop.

## Test plan
- Sprite 0 at (100,50), enabled, RAM all 0xF00 → so_rgb = 0xF00 for x 100..131, y 50..81, 2 cycles after the coordinate; si_rgb elsewhere.
- Sprites 0 (0x0F0) and 1 (0x00F) both at (200,200) → overlap shows 0x0F0. After the next frame start, collision = 2'b11 (NUM_SPR=2 view).
- Sprite pixel (dx=0) = 0x123, others KEY_COLOR, hmirror=1 at (10,10) → 0x123 appears at x=41 only.
- Write x_0=300 mid-frame → sprite stays at the old x until (0,0), then moves. A write on the frame-start cycle moves it one frame later.
- Sprite at x=630, width 32 → visible at 630..639 only, no wrap at x=0. Bypass=1 → so_rgb == si_rgb delayed by 2.
- Assert reset mid-frame → so_rgb=0 and collision=0 immediately; after release, no sprite shows until re-enabled.
